// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit bitwise logic unit between two
// requesters, with a registered operand path and a tagged valid/ready response port.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [1:0]       req0_sel_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [1:0]       req1_sel_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [1:0]       alu_sel_o,
    input  logic [WIDTH-1:0] alu_e_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_e_o,
    output logic             busy_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q;
    logic             last_grant_q;
    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       sel_q;
    logic [WIDTH-1:0] e_q;

    logic             idle;
    logic             gnt0;
    logic             gnt1;

    // Tie goes to whichever requester was not granted last; rst_ni gating keeps
    // both readies low while reset is held.
    always_comb begin
        idle = (state_q == IDLE) && rst_ni;
        gnt0 = idle && req0_valid_i && (!req1_valid_i || last_grant_q);
        gnt1 = idle && req1_valid_i && (!req0_valid_i || !last_grant_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            e_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_q          <= gnt1 ? req1_a_i   : req0_a_i;
                        b_q          <= gnt1 ? req1_b_i   : req0_b_i;
                        sel_q        <= gnt1 ? req1_sel_i : req0_sel_i;
                        id_q         <= gnt1;
                        last_grant_q <= gnt1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    e_q     <= alu_e_i;
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign alu_sel_o    = sel_q;
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_id_o     = id_q;
    assign rsp_e_o      = e_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: vector table for single ops plus hand-written
// contention, backpressure, mid-op reset and back-to-back sequences.
module tb_logic_unit_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]       req0_sel, req1_sel;
    logic [WIDTH-1:0] alu_a, alu_b, alu_e;
    logic [1:0]       alu_sel;
    logic             rsp_valid, rsp_ready, rsp_id, busy;
    logic [WIDTH-1:0] rsp_e;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared logic unit.
    always_comb begin
        alu_e = '0;
        case (alu_sel)
            2'b00: alu_e = alu_a & alu_b;
            2'b01: alu_e = alu_a | alu_b;
            2'b10: alu_e = alu_a ^ alu_b;
            default: alu_e = ~alu_a;
        endcase
    end

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_sel_i(req0_sel),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_sel_i(req1_sel),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel), .alu_e_i(alu_e),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_e_o(rsp_e), .busy_o(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       sel;
        logic [WIDTH-1:0] exp_e;
    } vec_t;

    vec_t vecs[4];
    time  t_acc[$];

    // Caller is at posedge+1; returns at posedge+1 right after the response handshake.
    task automatic do_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] sel, input logic [WIDTH-1:0] exp_e);
        int n = 0;
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", id ? req1_ready : req0_ready, 1);
        check("other_ready", id ? req0_ready : req1_ready, 0);
        @(posedge clk);
        t_acc.push_back($time);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_busy", busy, 1);
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
        check("exec_alu_sel", alu_sel, sel);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_e", rsp_e, exp_e);
        check("rsp_id", rsp_id, id);
        @(posedge clk);
        #1;
        check("post_hs_busy", busy, 0);
        check("post_hs_alu_a_held", alu_a, a);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic       grants[$];
    logic       rsps[$];
    logic [WIDTH-1:0] hold_e;

    initial begin
        vecs[0] = '{1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b00, 32'hF000_F000};
        vecs[1] = '{1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 2'b01, 32'h1F3F_5F7F};
        vecs[2] = '{1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 2'b10, 32'h1D3B_5977};
        vecs[3] = '{1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 2'b11, 32'hEDCB_A987};

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_a = '0; req1_b = '0; req1_sel = '0;
        rsp_ready = 1'b0;
        #2;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_e", rsp_e, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        do_reset();

        foreach (vecs[i]) do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp_e);

        // Contention: first tie after reset goes to requester 0, then strict alternation.
        do_reset();
        rsp_ready = 1'b1;
        req0_a = 32'hAAAA_0000; req0_b = 32'h0F0F_0F0F; req0_sel = 2'b01;
        req1_a = 32'h5555_FFFF; req1_b = 32'hFFFF_0000; req1_sel = 2'b10;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) check("both_ready", 1, 0);
            if (req0_ready) grants.push_back(1'b0);
            if (req1_ready) grants.push_back(1'b1);
            if (rsp_valid) begin
                rsps.push_back(rsp_id);
                check("cont_rsp_e", rsp_e, rsp_id ? 32'hAAAA_FFFF : 32'hAFAF_0F0F);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("cont_grant_count", grants.size(), 4);
        check("cont_rsp_count", rsps.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check("cont_grant_order", grants[i], i % 2);
            if (i < rsps.size()) check("cont_rsp_order", rsps[i], i % 2);
        end

        // Backpressure: hold rsp_ready low 5 cycles in RESP with requester 1 waiting.
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00; req0_sel = 2'b00;
        @(negedge clk);
        check("bp_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 32'h0F0F_0F0F; req1_sel = 2'b11;
        @(negedge clk);
        @(negedge clk);
        hold_e = rsp_e;
        check("bp_first_e", hold_e, 32'hF000_F000);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_e", rsp_e, 32'hF000_F000);
            check("bp_id", rsp_id, 0);
            check("bp_ready1", req1_ready, 0);
            check("bp_busy", busy, 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_done_busy", busy, 0);
        @(negedge clk);
        check("bp_next_ready1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("bp_next_e", rsp_e, 32'hEDCB_A987);
        @(posedge clk); #1;

        // Reset during EXEC drops the op; next tie still goes to requester 0.
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1111_1111; req1_sel = 2'b00;
        @(negedge clk);
        check("mid_accept", req1_ready, 1);
        @(posedge clk); #1;
        check("mid_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready1", req1_ready, 0);
        req0_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_tie_r0", req0_ready, 1);
        check("mid_tie_r1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("mid_rsp_id", rsp_id, 0);
        @(posedge clk); #1;

        // Back-to-back single requester: acceptances exactly 3 cycles apart.
        t_acc.delete();
        for (int i = 1; i < 4; i++) do_op(1'b1, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp_e);
        check("b2b_count", t_acc.size(), 3);
        for (int i = 1; i < t_acc.size(); i++) check("b2b_interval", t_acc[i] - t_acc[i-1], 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOT, 2-bit select) between two requesters. Each requester hands over an operand pair and select with a valid/ready handshake. The block drives the shared unit's operand and select inputs from registers and captures the unit's combinational result. It then returns the result, tagged with the requester id, through a valid/ready response port. It sits between the ALU's operand sources and the logic sub-unit of the 32-bit ALU.

## Interface
- WIDTH, 32, operand/result width in bits (≥1).

- clk_i  input  1  clock; all state changes on rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- req0_valid_i  input  1  requester 0 has an operation.
- req0_ready_o  output  1  requester 0 operation accepted this cycle.
- req0_a_i, req0_b_i  input  WIDTH  requester 0 operands.
- req0_sel_i  input  2  requester 0 op: 00 AND, 01 OR, 10 XOR, 11 NOT a.
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_sel_i: same as requester 0, for requester 1.
- alu_a_o, alu_b_o  output  WIDTH  operands to the shared logic unit.
- alu_sel_o  output  2  select to the shared logic unit.
- alu_e_i  input  WIDTH  combinational result from the shared logic unit.
- rsp_valid_o  output  1  response available.
- rsp_ready_i  input  1  consumer accepts the response.
- rsp_id_o  output  1  requester that issued the response (0/1).
- rsp_e_o  output  WIDTH  result.
- busy_o  output  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The winner is computed combinationally from req*_valid_i and the last_grant pointer.
  - If one requester is valid, it wins. If both are valid, the requester ≠ last_grant wins.
  - The winner's ready_o is high in the same cycle. The loser's ready is low, and both are low outside IDLE.
  - On the edge with valid&ready: latch the winner's a, b and sel into the operand registers, latch its id, set last_grant to the winner, go to EXEC.
- EXEC: the operand registers drive alu_*_o. At the end of the cycle, capture alu_e_i into rsp_e_o and go to RESP.
- RESP:
  - rsp_valid_o is high. rsp_e_o and rsp_id_o are stable until the handshake.
  - On rsp_valid_o & rsp_ready_i, go to IDLE.
  - A backpressured response stalls the block indefinitely. No new requests are accepted during the stall.
- alu_*_o hold the last issued operands in IDLE and RESP; they change only on acceptance.
- Requesters keep valid and data stable until ready. The block does not check this.
- A requester may drop valid while not granted; no operation is recorded.
- The block does no arithmetic: the result is exactly alu_e_i, with no width change.

## Timing
- Reset (rst_ni low, asynchronous):
  - state = IDLE, last_grant = 1, so requester 0 wins the first tie.
  - rsp_valid_o = 0, rsp_id_o = 0, rsp_e_o = 0, alu_a_o = alu_b_o = 0, alu_sel_o = 00, busy_o = 0.
  - req*_ready_o = 0 while reset is asserted.
- Reset mid-operation (EXEC or RESP) drops the pending op and response immediately. No partial response is emitted.
- Latency:
  - Acceptance edge k.
  - EXEC during cycle k+1.
  - rsp_valid_o high from cycle k+2.
- Minimum issue interval is 3 cycles (accept, exec, response handshake in the first RESP cycle).
- A new acceptance can occur in the cycle after the response handshake (IDLE).
- Under continuous contention, grants strictly alternate 0,1,0,1.
- A single active requester is granted back-to-back without waiting for the other.

## Test plan
- Single op: after reset, req0 valid with a=0xF0F0_F0F0, b=0xFF00_FF00, sel=00 -> req0_ready_o high in the same cycle; rsp_valid_o 2 cycles after acceptance with rsp_e_o=0xF000_F000, rsp_id_o=0.
- All selects: req1 with a=0x1234_5678, b=0x0F0F_0F0F, sel=01/10/11 -> rsp_e_o=0x1F3F_5F7F / 0x1D3B_5977 / 0xEDCB_A987, id=1.
- Contention: both valid continuously for 4 ops -> grant order 0,1,0,1; ready never high for both in one cycle; responses in the same order.
- Backpressure: rsp_ready_i low for 5 cycles in RESP -> rsp_valid_o, rsp_e_o and rsp_id_o stable; req*_ready_o low; busy_o high; normal completion when rsp_ready_i rises.
- Reset mid-op: assert rst_ni low during EXEC -> rsp_valid_o=0 and alu outputs=0 immediately; after release, the first tie goes to req0.
- Back-to-back single requester: req1 valid for 3 ops while req0 idle -> 3 acceptances, each 3 cycles apart with rsp_ready_i tied high.
